spine_port_arbiter: RTL and testbench
=====================================

Name: spine_port_arbiter

Overview:
Cycle-level switch core of a group spine. It accepts flits on 11 spine input ports, resolves each head flit to an output port through the group routing table, and arbitrates each output round-robin with wormhole packet locking. Each output has a one-entry output register. Flits with unroutable destinations are discarded and counted. It sits between the spine link/leaf receive buffers and the spine transmit ports.

Parameters:
GROUP_ID, 4'b0100, local group number; passed to the routing tables.
NUM_PORTS, 11, spine ports 1..11, held at vector index 0..10. Fixed by the port encoding; not to be overridden.
DATA_W, 64, flit payload width.
CNT_W, 16, drop counter width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  NUM_PORTS  per-input flit valid
in_last  in  NUM_PORTS  per-input last flit of packet
in_dest  in  NUM_PORTS*6  per-input {GroupID[3:0],LeafID[1:0]}; sampled on head flits only
in_data  in  NUM_PORTS*DATA_W  per-input payload
in_ready  out  NUM_PORTS  per-input accept
out_valid  out  NUM_PORTS  per-output flit valid (registered)
out_last  out  NUM_PORTS  per-output last flag (registered)
out_data  out  NUM_PORTS*DATA_W  per-output payload (registered)
out_src  out  NUM_PORTS*4  per-output source port number 1..11 (registered)
out_ready  in  NUM_PORTS  per-output downstream accept
drop_pulse  out  1  one-cycle pulse for each cycle in which at least one flit is dropped
drop_cnt  out  CNT_W  saturating count of dropped packets (head flits)

Behaviour:
- Reset (async assert, sync deassert at the clk edge): out_valid=0, out_last=0, out_data=0, out_src=0, drop_pulse=0, drop_cnt=0. All locks are cleared, all RR pointers = 0, all drop-mode flags = 0. Reset mid-packet abandons the packet with no recovery flit.
- Handshakes: transfer on an input = in_valid&in_ready; transfer on an output = out_valid&out_ready.
  - in_ready is combinational from in_valid, lock/pointer state and out_valid/out_ready.
  - A valid flit must be held stable until accepted.
- Per-input state:
  - idle: route = routing_table(in_dest).
  - fwd: route = latched route register; in_dest is ignored.
  - drop: the flit is discarded.
- Route 0 on a head flit:
  - in_ready=1 and the flit is discarded.
  - drop_pulse=1 next cycle; drop_cnt increments (saturates at all-ones).
  - If in_last=0, the input enters drop mode and discards every flit, with in_ready=1, until an accepted in_last=1 flit, then returns to idle.
  - Body-flit drops pulse drop_pulse but do not increment drop_cnt.
- Per-output o (port o+1): requesters are inputs in idle or fwd state with in_valid and route==o+1.
  - Locked[o]: only the owner input may be granted.
  - Unlocked: round-robin search starting at ptr[o], wrapping 10->0.
  - Self-route (input i to output i) is legal.
- Output stage can_load[o] = !out_valid[o] | out_ready[o]. A granted input gets in_ready=1 only if can_load[o].
- On transfer, next cycle: out_valid[o]=1 and data/last/src are loaded.
  - Latency is exactly 1 cycle input accept to out_valid.
  - Full throughput: one flit per cycle per output under continuous out_ready=1.
  - out_valid with no new load and out_ready=1 gives out_valid=0 next cycle.
- Lock rules:
  - Accepted head flit with last=0: Locked[o]=1, owner=i, input i enters fwd with its route latched.
  - Accepted flit with last=1: Locked[o]=0, input returns to idle, ptr[o]=(owner+1) mod 11.
  - A single-flit packet (head with last=1) locks nothing and advances ptr.
- Simultaneous events: an output register may unload and reload in the same cycle. Drops on several inputs in one cycle give a single drop_pulse, and drop_cnt increments by the number of head flits dropped that cycle (saturating).
- The output register holds its value while out_valid=1 and out_ready=0. No flit is ever duplicated or lost except by the defined drops.

Decomposition:
- Package spine_pkg holds:
  - NUM_PORTS=11, DEST_W=6, PORT_W=4;
  - port-code constants PORT_INVALID=0, PORT_LEAF1..4=1..4, PORT_SPINE_FIRST=5, PORT_SPINE_LAST=11;
  - the input state encoding {IDLE, FWD, DROP}.
- Instantiate the group routing table spine_routing_table_grp8 (GROUP_ID passed through) once per input.
- One natural sub-module: spine_rr_arb11, an 11-requester round-robin arbiter with pointer input, one-hot grant and lock/owner override. One instance per output.

Test Plan:
- Single-flit route, GROUP_ID=4: input 5 sends dest=6'b0100_10, last=1, data=0xA5 -> out_valid[2] one cycle later, out_src[2]=6, out_data=0xA5; ptr[2]=6.
- Inter-group: input 0 sends dest=6'b0001_00 -> output index 4 (port 5). dest=6'b1000_11 -> output index 10 (port 11).
- RR fairness: inputs 1, 3 and 7 all send single-flit packets to dest 6'b0011_00 continuously with out_ready=1 -> output 6 grants 1,3,7,1,3,7, one flit per cycle.
- Wormhole lock: input 2 sends a 4-flit packet to port 1 while input 9 requests port 1 from cycle 1 -> all 4 flits of input 2 pass contiguously, then input 9 is granted; in_dest changes on body flits are ignored.
- Drop: input 4 sends dest=6'b0000_01 with last=0, then 2 more flits, the last with last=1 -> in_ready=1 throughout, 3 drop_pulse cycles, drop_cnt=1, no out_valid.
- Backpressure and reset: hold out_ready[3]=0 with a flit loaded -> out_data is stable and the competing input sees in_ready=0. Assert rst_n=0 mid-packet -> all out_valid=0 immediately; after release the next head flit routes normally.

Source files
------------

// File: rtl/spine_pkg.sv
// Shared constants, port codes and input-state encoding for the spine switch core.
package spine_pkg;

   localparam int NUM_PORTS = 11;
   localparam int DEST_W    = 6;
   localparam int PORT_W    = 4;

   localparam logic [PORT_W-1:0] PORT_INVALID     = 4'd0;
   localparam logic [PORT_W-1:0] PORT_LEAF1       = 4'd1;
   localparam logic [PORT_W-1:0] PORT_LEAF2       = 4'd2;
   localparam logic [PORT_W-1:0] PORT_LEAF3       = 4'd3;
   localparam logic [PORT_W-1:0] PORT_LEAF4       = 4'd4;
   localparam logic [PORT_W-1:0] PORT_SPINE_FIRST = 4'd5;
   localparam logic [PORT_W-1:0] PORT_SPINE_LAST  = 4'd11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FWD  = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   typedef struct packed {
      logic [3:0] grp;
      logic [1:0] leaf;
   } dest_t;

   function automatic logic [PORT_W-1:0] leaf_port(input logic [1:0] leaf);
      case (leaf)
         2'd0:    return PORT_LEAF1;
         2'd1:    return PORT_LEAF2;
         2'd2:    return PORT_LEAF3;
         default: return PORT_LEAF4;
      endcase
   endfunction

endpackage

// File: rtl/spine_routing_table_grp8.sv
// Group routing table: own group -> leaf ports 1..4, groups 1..8 (minus own) -> spine ports 5..11.
module spine_routing_table_grp8 import spine_pkg::*; #(
   parameter logic [3:0] GROUP_ID = 4'b0100
) (
   input  logic [DEST_W-1:0] dest,
   output logic [PORT_W-1:0] port
);

   dest_t             d;
   logic [PORT_W-1:0] spine;

   assign d = dest_t'(dest);

   always_comb begin
      port  = PORT_INVALID;
      spine = PORT_INVALID;
      if (d.grp == GROUP_ID) begin
         port = leaf_port(d.leaf);
      end else if (d.grp >= 4'd1 && d.grp <= 4'd8) begin
         // own group takes no spine slot, so groups above it shift down by one
         spine = (d.grp < GROUP_ID) ? PORT_SPINE_FIRST + d.grp - 4'd1
                                    : PORT_SPINE_FIRST + d.grp - 4'd2;
         if (spine <= PORT_SPINE_LAST) port = spine;
      end
   end

endmodule

// File: rtl/spine_rr_arb11.sv
// 11-requester round-robin arbiter; a held lock restricts the grant to the owner.
module spine_rr_arb11 import spine_pkg::*; (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PORT_W-1:0]    ptr,
   input  logic                 locked,
   input  logic [PORT_W-1:0]    owner,
   output logic [NUM_PORTS-1:0] gnt
);

   logic [4:0] idx;
   logic       found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      if (locked) begin
         gnt = req & (NUM_PORTS'(1) << owner);
      end else begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = {1'b0, ptr} + 5'(k);
            if (idx >= 5'(NUM_PORTS)) idx = idx - 5'(NUM_PORTS);
            if (!found && req[idx[3:0]]) begin
               gnt[idx[3:0]] = 1'b1;
               found         = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spine_port_arbiter.sv
// Spine switch core: per-input routing, per-output RR wormhole arbitration, one-entry output regs.
module spine_port_arbiter import spine_pkg::*; #(
   parameter logic [3:0] GROUP_ID = 4'b0100,
   parameter int         DATA_W   = 64,
   parameter int         CNT_W    = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_PORTS-1:0]                 in_valid,
   input  logic [NUM_PORTS-1:0]                 in_last,
   input  logic [NUM_PORTS-1:0][DEST_W-1:0]     in_dest,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]     in_data,
   output logic [NUM_PORTS-1:0]                 in_ready,
   output logic [NUM_PORTS-1:0]                 out_valid,
   output logic [NUM_PORTS-1:0]                 out_last,
   output logic [NUM_PORTS-1:0][DATA_W-1:0]     out_data,
   output logic [NUM_PORTS-1:0][PORT_W-1:0]     out_src,
   input  logic [NUM_PORTS-1:0]                 out_ready,
   output logic                                 drop_pulse,
   output logic [CNT_W-1:0]                     drop_cnt
);

   localparam int NP = NUM_PORTS;

   logic [NP-1:0][1:0]        st_q;
   logic [NP-1:0][PORT_W-1:0] route_q, lut_route, route;
   logic [NP-1:0][NP-1:0]     req, gnt, acc;   // [output][input]
   logic [NP-1:0]             lock_q;
   logic [NP-1:0][PORT_W-1:0] owner_q, ptr_q;
   logic [NP-1:0]             can_load, fwd_acc, head_drop, body_drop;
   logic [NP-1:0][PORT_W-1:0] sel_idx;
   logic [NP-1:0][DATA_W-1:0] sel_data;
   logic [NP-1:0]             sel_last;
   logic [PORT_W-1:0]         n_head;
   logic [CNT_W:0]            cnt_sum;

   for (genvar i = 0; i < NP; i++) begin : g_in
      spine_routing_table_grp8 #(.GROUP_ID(GROUP_ID)) u_rt (
         .dest (in_dest[i]),
         .port (lut_route[i])
      );
      assign route[i]     = (st_q[i] == ST_FWD) ? route_q[i] : lut_route[i];
      assign head_drop[i] = in_valid[i] && st_q[i] == ST_IDLE && lut_route[i] == PORT_INVALID;
      assign body_drop[i] = in_valid[i] && st_q[i] == ST_DROP;
   end

   for (genvar o = 0; o < NP; o++) begin : g_out
      for (genvar i = 0; i < NP; i++) begin : g_req
         assign req[o][i] = in_valid[i] && st_q[i] != ST_DROP && route[i] == PORT_W'(o + 1);
      end
      spine_rr_arb11 u_arb (
         .req    (req[o]),
         .ptr    (ptr_q[o]),
         .locked (lock_q[o]),
         .owner  (owner_q[o]),
         .gnt    (gnt[o])
      );
      assign can_load[o] = !out_valid[o] || out_ready[o];
      assign acc[o]      = can_load[o] ? gnt[o] : '0;
   end

   // each input routes to at most one output, so at most one acc bit per input is set
   always_comb begin
      fwd_acc  = '0;
      sel_idx  = '0;
      sel_data = '0;
      sel_last = '0;
      n_head   = '0;
      for (int o = 0; o < NP; o++) begin
         for (int i = 0; i < NP; i++) begin
            if (acc[o][i]) begin
               fwd_acc[i]  = 1'b1;
               sel_idx[o]  = PORT_W'(i);
               sel_data[o] = in_data[i];
               sel_last[o] = in_last[i];
            end
         end
      end
      for (int i = 0; i < NP; i++) begin
         in_ready[i] = fwd_acc[i] || head_drop[i] || st_q[i] == ST_DROP;
         n_head      = n_head + PORT_W'(head_drop[i]);
      end
   end

   assign cnt_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(n_head);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= '0;
         route_q <= '0;
      end else begin
         for (int i = 0; i < NP; i++) begin
            case (st_q[i])
               ST_IDLE: begin
                  if (head_drop[i] && !in_last[i]) begin
                     st_q[i] <= ST_DROP;
                  end else if (fwd_acc[i] && !in_last[i]) begin
                     st_q[i]    <= ST_FWD;
                     route_q[i] <= lut_route[i];
                  end
               end
               ST_FWD:  if (fwd_acc[i] && in_last[i]) st_q[i] <= ST_IDLE;
               ST_DROP: if (in_valid[i] && in_last[i]) st_q[i] <= ST_IDLE;
               default: st_q[i] <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= '0;
         out_last  <= '0;
         out_data  <= '0;
         out_src   <= '0;
         lock_q    <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
      end else begin
         for (int o = 0; o < NP; o++) begin
            if (|acc[o]) begin
               out_valid[o] <= 1'b1;
               out_data[o]  <= sel_data[o];
               out_last[o]  <= sel_last[o];
               out_src[o]   <= sel_idx[o] + PORT_W'(1);
               if (sel_last[o]) begin
                  lock_q[o] <= 1'b0;
                  ptr_q[o]  <= (sel_idx[o] == PORT_W'(NP - 1)) ? '0 : sel_idx[o] + PORT_W'(1);
               end else begin
                  lock_q[o]  <= 1'b1;
                  owner_q[o] <= sel_idx[o];
               end
            end else if (out_ready[o]) begin
               out_valid[o] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_pulse <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         drop_pulse <= |(head_drop | body_drop);
         drop_cnt   <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_spine_port_arbiter.sv
// Directed bench for spine_port_arbiter: routing vector table plus RR, wormhole, drop, backpressure and reset sequences.
module tb_spine_port_arbiter;

   localparam int NP     = 11;
   localparam int DATA_W = 64;
   localparam int CNT_W  = 4;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [NP-1:0]             in_valid, in_last, in_ready;
   logic [NP-1:0][5:0]        in_dest;
   logic [NP-1:0][DATA_W-1:0] in_data;
   logic [NP-1:0]             out_valid, out_last, out_ready;
   logic [NP-1:0][DATA_W-1:0] out_data;
   logic [NP-1:0][3:0]        out_src;
   logic                      drop_pulse;
   logic [CNT_W-1:0]          drop_cnt;

   int checks = 0;
   int errors = 0;

   spine_port_arbiter #(.GROUP_ID(4'b0100), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_last(in_last), .in_dest(in_dest), .in_data(in_data),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_src(out_src),
      .out_ready(out_ready),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          src;
      logic [5:0]  dest;
      logic [63:0] data;
      int          exp_o;   // -1 = dropped
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_in();
      in_valid = '0;
      in_last  = '0;
      in_dest  = '0;
      in_data  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_in();
      out_ready = '1;
      rst_n = 1'b0;
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic send(input int i, input logic [5:0] d, input logic l, input logic [63:0] x);
      in_valid[i] = 1'b1;
      in_dest[i]  = d;
      in_last[i]  = l;
      in_data[i]  = x;
   endtask

   initial begin
      int exp_cnt;
      logic [NP-1:0] mask;
      int rr_exp[6];

      vecs[0]  = '{5,  6'b0100_10, 64'hA5,   2};
      vecs[1]  = '{0,  6'b0001_00, 64'h1111, 4};
      vecs[2]  = '{0,  6'b1000_11, 64'h2222, 10};
      vecs[3]  = '{10, 6'b0100_00, 64'h3333, 0};
      vecs[4]  = '{3,  6'b0101_01, 64'h4444, 7};
      vecs[5]  = '{7,  6'b0010_11, 64'h5555, 5};
      vecs[6]  = '{6,  6'b0111_00, 64'h6666, 9};
      vecs[7]  = '{3,  6'b0100_11, 64'h7777, 3};
      vecs[8]  = '{9,  6'b0100_01, 64'h8888, 1};
      vecs[9]  = '{8,  6'b0000_10, 64'h9999, -1};
      vecs[10] = '{1,  6'b1001_00, 64'hAAAA, -1};
      vecs[11] = '{2,  6'b1111_11, 64'hBBBB, -1};
      vecs[12] = '{4,  6'b0110_10, 64'hCCCC, 8};
      vecs[13] = '{6,  6'b0011_00, 64'hDDDD, 6};

      clear_in();
      out_ready = '1;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_src", 64'(out_src), 64'd0);
      chk("rst_out_data_zero", 64'(out_data == '0), 64'd1);
      chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // single-flit routing table
      exp_cnt = 0;
      for (int v = 0; v < 14; v++) begin
         clear_in();
         send(vecs[v].src, vecs[v].dest, 1'b1, vecs[v].data);
         #1;
         chk($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'(NP'(1) << vecs[v].src));
         tick();
         mask = (vecs[v].exp_o < 0) ? '0 : NP'(1) << vecs[v].exp_o;
         chk($sformatf("v%0d_out_valid", v), 64'(out_valid), 64'(mask));
         if (vecs[v].exp_o >= 0) begin
            chk($sformatf("v%0d_out_data", v), out_data[vecs[v].exp_o], vecs[v].data);
            chk($sformatf("v%0d_out_src", v), 64'(out_src[vecs[v].exp_o]), 64'(vecs[v].src + 1));
            chk($sformatf("v%0d_out_last", v), 64'(out_last[vecs[v].exp_o]), 64'd1);
         end else begin
            exp_cnt++;
         end
         chk($sformatf("v%0d_drop_pulse", v), 64'(drop_pulse), 64'(vecs[v].exp_o < 0));
         chk($sformatf("v%0d_drop_cnt", v), 64'(drop_cnt), 64'(exp_cnt));
         clear_in();
         tick();
         chk($sformatf("v%0d_drain", v), 64'(out_valid), 64'd0);
      end

      // round-robin fairness on port 7
      do_reset();
      rr_exp = '{1, 3, 7, 1, 3, 7};
      send(1, 6'b0011_00, 1'b1, 64'h71);
      send(3, 6'b0011_00, 1'b1, 64'h73);
      send(7, 6'b0011_00, 1'b1, 64'h77);
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("rr%0d_in_ready", k), 64'(in_ready), 64'(NP'(1) << rr_exp[k]));
         tick();
         chk($sformatf("rr%0d_valid", k), 64'(out_valid), 64'(NP'(1) << 6));
         chk($sformatf("rr%0d_src", k), 64'(out_src[6]), 64'(rr_exp[k] + 1));
         chk($sformatf("rr%0d_data", k), out_data[6], 64'h70 + 64'(rr_exp[k]));
      end
      clear_in();
      tick();

      // wormhole lock: 4-flit packet from input 2 vs input 9 on port 1
      do_reset();
      for (int c = 0; c < 4; c++) begin
         send(2, (c == 0) ? 6'b0100_00 : 6'b0001_00, c == 3, 64'h100 + 64'(c));
         if (c == 1) send(9, 6'b0100_00, 1'b1, 64'h900);
         #1;
         chk($sformatf("wh%0d_in_ready", c), 64'(in_ready), 64'(NP'(1) << 2));
         tick();
         chk($sformatf("wh%0d_valid", c), 64'(out_valid), 64'd1);
         chk($sformatf("wh%0d_src", c), 64'(out_src[0]), 64'd3);
         chk($sformatf("wh%0d_data", c), out_data[0], 64'h100 + 64'(c));
         chk($sformatf("wh%0d_last", c), 64'(out_last[0]), 64'(c == 3));
      end
      in_valid[2] = 1'b0;
      #1;
      chk("wh_after_in_ready", 64'(in_ready), 64'(NP'(1) << 9));
      tick();
      chk("wh_after_src", 64'(out_src[0]), 64'd10);
      chk("wh_after_data", out_data[0], 64'h900);
      clear_in();
      tick();

      // multi-flit drop on input 4; body dest would be routable but is ignored
      do_reset();
      for (int c = 0; c < 3; c++) begin
         send(4, (c == 0) ? 6'b0000_01 : 6'b0100_00, c == 2, 64'h400 + 64'(c));
         #1;
         chk($sformatf("dr%0d_in_ready", c), 64'(in_ready), 64'(NP'(1) << 4));
         tick();
         chk($sformatf("dr%0d_pulse", c), 64'(drop_pulse), 64'd1);
         chk($sformatf("dr%0d_no_out", c), 64'(out_valid), 64'd0);
         chk($sformatf("dr%0d_cnt", c), 64'(drop_cnt), 64'd1);
      end
      clear_in();
      tick();
      chk("dr_pulse_clear", 64'(drop_pulse), 64'd0);
      send(4, 6'b0100_00, 1'b1, 64'h4F);
      tick();
      chk("dr_idle_again", 64'(out_valid), 64'd1);
      chk("dr_idle_src", 64'(out_src[0]), 64'd5);
      clear_in();
      tick();

      // simultaneous head drops on all inputs, then saturation of the 4-bit counter
      do_reset();
      for (int i = 0; i < NP; i++) send(i, 6'b0000_00, 1'b1, 64'(i));
      #1;
      chk("sat_in_ready", 64'(in_ready), 64'(NP'('1)));
      tick();
      chk("sat_pulse1", 64'(drop_pulse), 64'd1);
      chk("sat_cnt1", 64'(drop_cnt), 64'd11);
      tick();
      chk("sat_cnt2", 64'(drop_cnt), 64'd15);
      clear_in();
      tick();
      chk("sat_pulse_clear", 64'(drop_pulse), 64'd0);
      chk("sat_cnt_hold", 64'(drop_cnt), 64'd15);

      // backpressure on port 4 (index 3)
      do_reset();
      out_ready[3] = 1'b0;
      send(0, 6'b0100_11, 1'b1, 64'h11);
      tick();
      clear_in();
      send(1, 6'b0100_11, 1'b1, 64'h22);
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
         tick();
         chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'(NP'(1) << 3));
         chk($sformatf("bp%0d_data", c), out_data[3], 64'h11);
         chk($sformatf("bp%0d_src", c), 64'(out_src[3]), 64'd1);
      end
      out_ready[3] = 1'b1;
      #1;
      chk("bp_release_in_ready", 64'(in_ready), 64'(NP'(1) << 1));
      tick();
      chk("bp_reload_valid", 64'(out_valid), 64'(NP'(1) << 3));
      chk("bp_reload_data", out_data[3], 64'h22);
      chk("bp_reload_src", 64'(out_src[3]), 64'd2);
      clear_in();
      tick();
      chk("bp_unload", 64'(out_valid), 64'd0);

      // reset in the middle of a packet
      send(5, 6'b0100_01, 1'b0, 64'h55);
      tick();
      chk("mr_loaded", 64'(out_valid), 64'(NP'(1) << 1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_async_clear", 64'(out_valid), 64'd0);
      clear_in();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send(6, 6'b0100_01, 1'b1, 64'h66);
      #1;
      chk("mr_in_ready", 64'(in_ready), 64'(NP'(1) << 6));
      tick();
      chk("mr_valid", 64'(out_valid), 64'(NP'(1) << 1));
      chk("mr_src", 64'(out_src[1]), 64'd7);
      chk("mr_data", out_data[1], 64'h66);
      clear_in();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
